// File: rtl/bcd_seq_converter.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock, start/busy/done handshake.
// Optional build macro SIGNED_INPUT_EN: treat bin_in as two's complement and display its magnitude.
module bcd_seq_converter #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  negative_in,
  input  logic                  error_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  negative_sign,
  output logic                  error_out,
  output logic                  overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_FIN
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [BIN_W-1:0] r_bin;
  logic [BCD_W-1:0] r_bcd;
  logic             r_neg;
  logic             r_ovf;

  logic [BIN_W-1:0] w_mag;
  logic             w_neg;
  logic [BCD_W-1:0] w_adj;
  logic             w_top_adj;
  logic             w_shift_ovf;
  logic [BCD_W-1:0] w_bcd_next;
  logic [BIN_W-1:0] w_bin_next;

`ifdef SIGNED_INPUT_EN
  // The most negative input negates to itself, which read unsigned is 2^(BIN_W-1).
  always_comb begin
    w_neg = bin_in[BIN_W-1];
    w_mag = w_neg ? (~bin_in + {{(BIN_W-1){1'b0}}, 1'b1}) : bin_in;
  end
`else
  always_comb begin
    w_neg = negative_in;
    w_mag = bin_in;
  end
`endif

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_adj     = r_bcd;
    w_top_adj = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_bcd[4*d +: 4] >= 4'd5) begin
        w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
      end
    end
    if (r_bcd[BCD_W-1 -: 4] >= 4'd5) begin
      w_top_adj = 1'b1;
    end
  end

  // Dropping the carry out of the top digit leaves the lower digits exact, i.e. the value modulo 10^DIGITS.
  assign w_shift_ovf = w_top_adj | w_adj[BCD_W-1];
  assign w_bcd_next  = {w_adj[BCD_W-2:0], r_bin[BIN_W-1]};
  assign w_bin_next  = {r_bin[BIN_W-2:0], 1'b0};

  // NOTE: state and outputs use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_bin         <= '0;
      r_bcd         <= '0;
      r_neg         <= 1'b0;
      r_ovf         <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      bcd_out       <= '0;
      negative_sign <= 1'b0;
      error_out     <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            r_bin <= w_mag;
            r_neg <= w_neg;
            r_bcd <= '0;
            r_ovf <= 1'b0;
            r_cnt <= CNT_W'(BIN_W - 1);
            if (error_in) begin
              // Error short-circuits the conversion; bcd_out keeps the last good result.
              r_state       <= S_FIN;
              done          <= 1'b1;
              error_out     <= 1'b1;
              overflow      <= 1'b0;
              negative_sign <= w_neg;
            end else begin
              r_state <= S_SHIFT;
            end
          end
        end

        S_SHIFT: begin
          r_bcd <= w_bcd_next;
          r_bin <= w_bin_next;
          r_ovf <= r_ovf | w_shift_ovf;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_state       <= S_FIN;
            done          <= 1'b1;
            bcd_out       <= w_bcd_next;
            overflow      <= r_ovf | w_shift_ovf;
            error_out     <= 1'b0;
            negative_sign <= r_neg;
          end
        end

        S_FIN: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Scoreboard bench for bcd_seq_converter: one 16-bit/5-digit instance and one 16-bit/4-digit instance.
// Expected results are queued at stimulus time and compared by per-instance monitors on each done pulse.
module tb_bcd_seq_converter;

`ifdef SIGNED_INPUT_EN
  localparam bit SIGNED_MODE = 1'b1;
`else
  localparam bit SIGNED_MODE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a, start_b;
  logic [15:0] bin_in;
  logic        negative_in, error_in;

  logic        busy_a, done_a, neg_a, err_a, ovf_a;
  logic [19:0] bcd_a;
  logic        busy_b, done_b, neg_b, err_b, ovf_b;
  logic [15:0] bcd_b;

  always #5 clk = ~clk;

  bcd_seq_converter #(.BIN_W(16), .DIGITS(5)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .bin_in(bin_in),
    .negative_in(negative_in), .error_in(error_in),
    .busy(busy_a), .done(done_a), .bcd_out(bcd_a),
    .negative_sign(neg_a), .error_out(err_a), .overflow(ovf_a)
  );

  bcd_seq_converter #(.BIN_W(16), .DIGITS(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .bin_in(bin_in),
    .negative_in(negative_in), .error_in(error_in),
    .busy(busy_b), .done(done_b), .bcd_out(bcd_b),
    .negative_sign(neg_b), .error_out(err_b), .overflow(ovf_b)
  );

  typedef struct packed {
    logic [19:0] bcd;
    logic        neg;
    logic        err;
    logic        ovf;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done_a) begin
      if (sb_a.size() == 0) begin
        check("a_unexpected_done", {31'd0, done_a}, 32'd0);
      end else begin
        e = sb_a.pop_front();
        check("a_bcd", {12'd0, bcd_a}, {12'd0, e.bcd});
        check("a_neg", {31'd0, neg_a}, {31'd0, e.neg});
        check("a_err", {31'd0, err_a}, {31'd0, e.err});
        check("a_ovf", {31'd0, ovf_a}, {31'd0, e.ovf});
        check("a_busy_at_done", {31'd0, busy_a}, 32'd1);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (done_b) begin
      if (sb_b.size() == 0) begin
        check("b_unexpected_done", {31'd0, done_b}, 32'd0);
      end else begin
        e = sb_b.pop_front();
        check("b_bcd", {16'd0, bcd_b}, {12'd0, e.bcd});
        check("b_neg", {31'd0, neg_b}, {31'd0, e.neg});
        check("b_err", {31'd0, err_b}, {31'd0, e.err});
        check("b_ovf", {31'd0, ovf_b}, {31'd0, e.ovf});
        check("b_busy_at_done", {31'd0, busy_b}, 32'd1);
      end
    end
  end

  function automatic exp_t make_exp(input logic [15:0] v, input logic ng, input logic er,
                                    input logic [19:0] eb, input logic eo);
    exp_t e;
    e.bcd = eb;
    e.neg = SIGNED_MODE ? v[15] : ng;
    e.err = er;
    e.ovf = eo;
    return e;
  endfunction

  // One conversion on instance a (sel=0) or b (sel=1); checks latency, busy and return to idle.
  task automatic convert(input bit sel, input logic [15:0] v, input logic ng, input logic er,
                         input logic [19:0] eb, input logic eo, input int exp_lat, input string tag);
    int n;
    bit seen;
    if (sel) sb_b.push_back(make_exp(v, ng, er, eb, eo));
    else     sb_a.push_back(make_exp(v, ng, er, eb, eo));
    @(posedge clk); #1;
    bin_in = v; negative_in = ng; error_in = er;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    seen = 1'b0;
    n = 1;
    while (!seen && n <= 40) begin
      @(negedge clk);
      if (n == 1) check({tag, "_busy_c1"}, {31'd0, sel ? busy_b : busy_a}, 32'd1);
      if (sel ? done_b : done_a) seen = 1'b1;
      else n++;
    end
    check({tag, "_latency"}, n, exp_lat);
    @(posedge clk); #1;
    check({tag, "_idle_after"}, {31'd0, sel ? busy_b : busy_a}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, dn, lat, lat2;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    bin_in = '0; negative_in = 1'b0; error_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    check("rst_done", {31'd0, done_a}, 32'd0);
    check("rst_bcd", {12'd0, bcd_a}, 32'd0);
    check("rst_neg", {31'd0, neg_a}, 32'd0);
    check("rst_err", {31'd0, err_a}, 32'd0);
    check("rst_ovf", {31'd0, ovf_a}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    convert(0, 16'd65535, 1'b0, 1'b0, SIGNED_MODE ? 20'h00001 : 20'h65535, 1'b0, 17, "a_max");
    convert(0, 16'd0,     1'b0, 1'b0, 20'h00000, 1'b0, 17, "a_zero");
    convert(0, 16'd1234,  1'b1, 1'b0, 20'h01234, 1'b0, 17, "a_1234");
    convert(0, 16'd777,   1'b1, 1'b1, 20'h01234, 1'b0, 1,  "a_error");
    convert(0, 16'hFB2E,  1'b0, 1'b0, SIGNED_MODE ? 20'h01234 : 20'h64302, 1'b0, 17, "a_fb2e");
    convert(0, 16'h8000,  1'b1, 1'b0, 20'h32768, 1'b0, 17, "a_8000");

    // Start pulses during a conversion must be ignored.
    sb_a.push_back(make_exp(16'd2468, 1'b0, 1'b0, 20'h02468, 1'b0));
    @(posedge clk); #1;
    bin_in = 16'd2468; negative_in = 1'b0; error_in = 1'b0; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    dn = 0; lat = 0;
    for (cyc = 1; cyc <= 30; cyc++) begin
      if (cyc == 5 || cyc == 10) begin
        start_a = 1'b1; bin_in = 16'd4321;
      end else begin
        start_a = 1'b0;
      end
      @(negedge clk);
      if (done_a) begin
        dn++;
        if (lat == 0) lat = cyc;
      end
      @(posedge clk); #1;
    end
    start_a = 1'b0;
    check("ignore_start_dones", dn, 1);
    check("ignore_start_latency", lat, 17);

    // Reset at cycle 8 aborts a conversion without a done pulse.
    @(posedge clk); #1;
    bin_in = 16'd5555; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    dn = 0;
    for (cyc = 1; cyc <= 25; cyc++) begin
      rst_n = (cyc != 8);
      @(negedge clk);
      if (done_a) dn++;
      if (cyc == 9) begin
        check("midrst_busy", {31'd0, busy_a}, 32'd0);
        check("midrst_bcd", {12'd0, bcd_a}, 32'd0);
        check("midrst_neg", {31'd0, neg_a}, 32'd0);
        check("midrst_err", {31'd0, err_a}, 32'd0);
        check("midrst_ovf", {31'd0, ovf_a}, 32'd0);
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    check("midrst_no_done", dn, 0);

    convert(0, 16'd9, 1'b0, 1'b0, 20'h00009, 1'b0, 17, "a_after_rst");

    // Start held high: back-to-back conversions with one idle cycle between.
    sb_a.push_back(make_exp(16'd4095, 1'b0, 1'b0, 20'h04095, 1'b0));
    sb_a.push_back(make_exp(16'd4095, 1'b0, 1'b0, 20'h04095, 1'b0));
    @(posedge clk); #1;
    bin_in = 16'd4095; start_a = 1'b1;
    @(posedge clk); #1;
    dn = 0; lat = 0; lat2 = 0;
    for (cyc = 1; cyc <= 50 && dn < 2; cyc++) begin
      @(negedge clk);
      if (done_a) begin
        dn++;
        if (dn == 1) lat = cyc;
        else begin
          lat2 = cyc;
          start_a = 1'b0;
        end
      end
      @(posedge clk); #1;
    end
    start_a = 1'b0;
    check("b2b_first_latency", lat, 17);
    check("b2b_second_latency", lat2, 35);
    @(posedge clk); #1;

    convert(1, 16'd12345, 1'b0, 1'b0, 20'h02345, 1'b1, 17, "b_12345");
    convert(1, 16'd9999,  1'b0, 1'b0, 20'h09999, 1'b0, 17, "b_9999");
    convert(1, 16'd65535, 1'b0, 1'b0, SIGNED_MODE ? 20'h00001 : 20'h05535,
            SIGNED_MODE ? 1'b0 : 1'b1, 17, "b_max");
    convert(1, 16'd10000, 1'b1, 1'b0, 20'h00000, 1'b1, 17, "b_10000");

    repeat (3) @(posedge clk);
    check("a_queue_empty", sb_a.size(), 0);
    check("b_queue_empty", sb_b.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
